// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshakes and memory bus bundle for mem_arbiter
//
// Purpose: groups the fetch port, load/store port, memory bus and stall
// outputs of mem_arbiter into one interface.
// Modports:
//   master - requesters and memory model: drive requests, bus_rdata, bus_ready
//   slave  - the arbiter: drives acks, read data, bus_* outputs and stalls
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // fetch port (read-only)
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  // load/store port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_sel;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // memory bus
  logic                  bus_ce;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [3:0]            bus_sel;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;
  logic                  bus_err;
  // pipeline stalls
  logic                  if_stall;
  logic                  mem_stall;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           bus_rdata, bus_ready,
    input  if_ack, if_rdata, mem_ack, mem_rdata, bus_ce, bus_we, bus_addr,
           bus_wdata, bus_sel, bus_err, if_stall, mem_stall
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
           bus_rdata, bus_ready,
    output if_ack, if_rdata, mem_ack, mem_rdata, bus_ce, bus_we, bus_addr,
           bus_wdata, bus_sel, bus_err, if_stall, mem_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and load/store stages
//
// Purpose: grants the shared memory bus to one requester at a time, registers
// its address/data/control onto the bus, completes on bus_ready or on a
// watchdog timeout, and produces per-stage stall signals.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous reset, active-low
//   port - mem_arbiter_if.slave: if_* fetch port, mem_* load/store port,
//          bus_* memory bus, if_stall / mem_stall
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (1..255 grant cycles)
// Optional: define ARB_ROUND_ROBIN_EN to alternate grants on ties
//           (default build: load/store always wins a tie).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  port
);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  logic [7:0]            wait_cnt;
  logic                  bus_ce_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic [3:0]            bus_sel_q;

  logic                  granted;
  logic                  timeout;
  logic                  if_done;
  logic                  mem_done;
  logic                  pick_mem;

  assign granted  = (state == GRANT_IF) || (state == GRANT_MEM);
  // bus_ready wins over the watchdog, so a coinciding ready is a clean completion
  assign timeout  = granted && (wait_cnt == WAIT_LAST) && !port.bus_ready;
  assign if_done  = (state == GRANT_IF)  && (port.bus_ready || timeout);
  assign mem_done = (state == GRANT_MEM) && (port.bus_ready || timeout);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = load/store port received the most recent grant
  logic last_mem;
  assign pick_mem = port.mem_req && (!port.if_req || !last_mem);
`else
  assign pick_mem = port.mem_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
      last_mem    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (pick_mem) begin
            state       <= GRANT_MEM;
            bus_ce_q    <= 1'b1;
            bus_we_q    <= port.mem_we;
            bus_addr_q  <= port.mem_addr;
            bus_wdata_q <= port.mem_wdata;
            bus_sel_q   <= port.mem_sel;
`ifdef ARB_ROUND_ROBIN_EN
            last_mem    <= 1'b1;
`endif
          end else if (port.if_req) begin
            state       <= GRANT_IF;
            bus_ce_q    <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= port.if_addr;
            bus_wdata_q <= '0;
            bus_sel_q   <= 4'b1111;
`ifdef ARB_ROUND_ROBIN_EN
            last_mem    <= 1'b0;
`endif
          end else begin
            bus_ce_q <= 1'b0;
            bus_we_q <= 1'b0;
          end
        end
        GRANT_IF, GRANT_MEM: begin
          // bus_* hold for the whole grant; requester inputs are not looked at
          if (if_done || mem_done) begin
            state    <= IDLE;
            bus_ce_q <= 1'b0;
            bus_we_q <= 1'b0;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          bus_ce_q <= 1'b0;
          bus_we_q <= 1'b0;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign port.bus_ce    = bus_ce_q;
  assign port.bus_we    = bus_we_q;
  assign port.bus_addr  = bus_addr_q;
  assign port.bus_wdata = bus_wdata_q;
  assign port.bus_sel   = bus_sel_q;
  assign port.bus_err   = timeout;

  assign port.if_ack    = if_done;
  assign port.mem_ack   = mem_done;
  // read data only passes on a real bus_ready completion; timeout returns 0
  assign port.if_rdata  = (if_done  && port.bus_ready) ? port.bus_rdata : '0;
  assign port.mem_rdata = (mem_done && port.bus_ready) ? port.bus_rdata : '0;

  assign port.if_stall  = port.if_req  && !if_done;
  assign port.mem_stall = port.mem_req && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_sel   = 4'b0000;
    bus.bus_rdata = '0;
    bus.bus_ready = 1'b0;
  endtask

  // leaves the bench at a negedge with reset released and the arbiter idle
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit          if_req;
    bit          mem_req;
    bit          mem_we;
    logic [31:0] if_addr;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    bit          exp_mem;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[5];

  // reference model state: one outstanding access record
  bit          acc_valid;
  bit          acc_mem;
  bit          acc_we;
  int          acc_age;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_sel;
  bit          model_last_mem;

  initial begin
    bit          win_mem;
    bit          prev_if_ack;
    bit          prev_mem_ack;
    int          rdy_pct;
    int          order[$];
    bit          e_tmo;
    bit          e_done;
    bit          e_if_ack;
    bit          e_mem_ack;
    bit          pick;
    logic [31:0] e_rd;

    clear_inputs();
    rst = 1'b0;

    // ---- reset: asserted mid-grant, takes effect without a clock edge
    @(negedge clk);
    rst = 1'b1;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.if_req = 1'b1;
    @(posedge clk);
    #2;
    check("rst_pre_ce", bus.bus_ce, 1);
    rst = 1'b0;
    bus.bus_ready = 1'b1;
    #1;
    check("rst_ce", bus.bus_ce, 0);
    check("rst_we", bus.bus_we, 0);
    check("rst_err", bus.bus_err, 0);
    check("rst_if_ack", bus.if_ack, 0);
    check("rst_mem_ack", bus.mem_ack, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_release_ce", bus.bus_ce, 0);

    // ---- table: single requests and ties from a fresh reset
    win_mem = !RR;
    vecs[0] = '{1, 0, 0, 32'h40,  32'h0,   32'h0,        4'h0, 0, 32'h40,  32'h0,        4'hF};
    vecs[1] = '{0, 1, 0, 32'h0,   32'h300, 32'h11112222, 4'hF, 1, 32'h300, 32'h11112222, 4'hF};
    vecs[2] = '{0, 1, 1, 32'h0,   32'h104, 32'hCAFE0001, 4'h4, 1, 32'h104, 32'hCAFE0001, 4'h4};
    vecs[3] = '{1, 1, 1, 32'h80,  32'h100, 32'h12345678, 4'h3, win_mem,
                win_mem ? 32'h100 : 32'h80, win_mem ? 32'h12345678 : 32'h0, win_mem ? 4'h3 : 4'hF};
    vecs[4] = '{1, 1, 0, 32'hFFC, 32'h8,   32'hAAAA5555, 4'hC, win_mem,
                win_mem ? 32'h8 : 32'hFFC, win_mem ? 32'hAAAA5555 : 32'h0, win_mem ? 4'hC : 4'hF};
    foreach (vecs[i]) begin
      do_reset();
      bus.if_req = vecs[i].if_req; bus.if_addr = vecs[i].if_addr;
      bus.mem_req = vecs[i].mem_req; bus.mem_we = vecs[i].mem_we;
      bus.mem_addr = vecs[i].mem_addr; bus.mem_wdata = vecs[i].wdata; bus.mem_sel = vecs[i].sel;
      #1;
      check("vec_idle_ce", bus.bus_ce, 0);
      @(negedge clk);
      bus.bus_ready = 1'b1;
      bus.bus_rdata = 32'hA5A50000 | 32'(i);
      #1;
      check("vec_ce", bus.bus_ce, 1);
      check("vec_we", bus.bus_we, vecs[i].exp_mem & vecs[i].mem_we);
      check("vec_addr", bus.bus_addr, vecs[i].exp_addr);
      check("vec_wdata", bus.bus_wdata, vecs[i].exp_wdata);
      check("vec_sel", bus.bus_sel, vecs[i].exp_sel);
      check("vec_mem_ack", bus.mem_ack, vecs[i].exp_mem);
      check("vec_if_ack", bus.if_ack, !vecs[i].exp_mem);
      check("vec_rdata", vecs[i].exp_mem ? bus.mem_rdata : bus.if_rdata, 32'hA5A50000 | 32'(i));
      @(negedge clk);
      clear_inputs();
      #1;
      check("vec_done_ce", bus.bus_ce, 0);
    end

    // ---- fetch with bus_ready on the 3rd bus_ce cycle
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    #1;
    check("fetch_idle_stall", bus.if_stall, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.bus_ready = (c == 3);
      bus.bus_rdata = (c == 3) ? 32'hDEADBEEF : 32'h5555AAAA;
      #1;
      check("fetch_ce", bus.bus_ce, 1);
      check("fetch_addr", bus.bus_addr, 32'h40);
      check("fetch_we", bus.bus_we, 0);
      check("fetch_ack", bus.if_ack, c == 3);
      check("fetch_rdata", bus.if_rdata, (c == 3) ? 32'hDEADBEEF : 32'h0);
      check("fetch_stall", bus.if_stall, c != 3);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    check("fetch_after_ce", bus.bus_ce, 0);

    // ---- tie, bus_ready every cycle: winner, IDLE gap, then the other
    do_reset();
    bus.bus_ready = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h100;
    bus.mem_wdata = 32'h12345678; bus.mem_sel = 4'b0011;
    #1;
    check("tie_k0_if_stall", bus.if_stall, 1);
    @(negedge clk); #1;
    check("tie_k1_we", bus.bus_we, win_mem);
    check("tie_k1_sel", bus.bus_sel, win_mem ? 4'b0011 : 4'b1111);
    check("tie_k1_mem_ack", bus.mem_ack, win_mem);
    check("tie_k1_if_stall", bus.if_stall, win_mem);
    @(negedge clk);
    if (win_mem) bus.mem_req = 1'b0; else bus.if_req = 1'b0;
    #1;
    check("tie_k2_ce", bus.bus_ce, 0);
    check("tie_k2_if_stall", bus.if_stall, win_mem);
    @(negedge clk); #1;
    check("tie_k3_addr", bus.bus_addr, win_mem ? 32'h80 : 32'h100);
    check("tie_k3_if_ack", bus.if_ack, win_mem);
    check("tie_k3_if_stall", bus.if_stall, 0);
    @(negedge clk);
    clear_inputs();

    // ---- watchdog timeout on a load, then ready coinciding with the last count
    do_reset();
    bus.mem_req = 1'b1; bus.mem_addr = 32'h200; bus.bus_rdata = 32'h77777777;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk); #1;
      check("tmo_ce", bus.bus_ce, 1);
      check("tmo_ack", bus.mem_ack, c == TO);
      check("tmo_err", bus.bus_err, c == TO);
      check("tmo_rdata", bus.mem_rdata, 0);
    end
    @(negedge clk);
    bus.mem_req = 1'b0;
    #1;
    check("tmo_after_ce", bus.bus_ce, 0);
    check("tmo_after_err", bus.bus_err, 0);
    @(negedge clk);
    bus.mem_req = 1'b1;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      bus.bus_ready = (c == TO); bus.bus_rdata = 32'hCAFEF00D;
      #1;
      if (c == TO) begin
        check("tmo_rdy_ack", bus.mem_ack, 1);
        check("tmo_rdy_err", bus.bus_err, 0);
        check("tmo_rdy_rdata", bus.mem_rdata, 32'hCAFEF00D);
      end
    end
    @(negedge clk);
    clear_inputs();

    // ---- async reset in the 2nd cycle of a store grant
    do_reset();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h44;
    @(negedge clk);
    @(negedge clk); #1;
    check("arst_c2_ce", bus.bus_ce, 1);
    #1;
    rst = 1'b0;
    bus.bus_ready = 1'b1;
    #1;
    check("arst_ce", bus.bus_ce, 0);
    check("arst_no_ack", bus.mem_ack, 0);
    @(negedge clk);
    bus.bus_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    check("arst_regrant_ce", bus.bus_ce, 1);
    check("arst_regrant_we", bus.bus_we, 1);
    @(negedge clk);
    clear_inputs();

    // ---- both requests held continuously: grant order
    do_reset();
    bus.if_req = 1'b1; bus.mem_req = 1'b1; bus.bus_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      if (bus.if_ack) order.push_back(0);
      if (bus.mem_ack) order.push_back(1);
      @(negedge clk);
    end
    check("order_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check("order_grant", order[k], RR ? (k % 2) : 1);
    clear_inputs();

    // ---- randomized traffic against the access-record model
    do_reset();
    acc_valid = 0; acc_age = 0; model_last_mem = 1;
    prev_if_ack = 0; prev_mem_ack = 0; rdy_pct = 40;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 100 == 0) rdy_pct = (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(10, 100));
      if (!bus.if_req || prev_if_ack) begin
        bus.if_req = prev_if_ack ? $urandom_range(0, 1) : ($urandom_range(0, 2) == 0);
        bus.if_addr = $urandom;
      end
      if (!bus.mem_req || prev_mem_ack) begin
        bus.mem_req = prev_mem_ack ? $urandom_range(0, 1) : ($urandom_range(0, 2) == 0);
        bus.mem_we = $urandom_range(0, 1);
        bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.mem_sel = 4'($urandom);
      end
      bus.bus_ready = ($urandom_range(1, 100) <= rdy_pct);
      bus.bus_rdata = $urandom;
      #1;
      e_tmo = acc_valid && !bus.bus_ready && (acc_age == TO - 1);
      e_done = acc_valid && (bus.bus_ready || e_tmo);
      e_if_ack = e_done && !acc_mem;
      e_mem_ack = e_done && acc_mem;
      e_rd = (e_done && bus.bus_ready) ? bus.bus_rdata : 32'h0;
      check("rnd_ce", bus.bus_ce, acc_valid);
      check("rnd_we", bus.bus_we, acc_valid && acc_we);
      check("rnd_if_ack", bus.if_ack, e_if_ack);
      check("rnd_mem_ack", bus.mem_ack, e_mem_ack);
      check("rnd_err", bus.bus_err, e_tmo);
      check("rnd_if_rdata", bus.if_rdata, e_if_ack ? e_rd : 32'h0);
      check("rnd_mem_rdata", bus.mem_rdata, e_mem_ack ? e_rd : 32'h0);
      check("rnd_if_stall", bus.if_stall, bus.if_req && !e_if_ack);
      check("rnd_mem_stall", bus.mem_stall, bus.mem_req && !e_mem_ack);
      if (acc_valid) begin
        check("rnd_addr", bus.bus_addr, acc_addr);
        check("rnd_wdata", bus.bus_wdata, acc_wdata);
        check("rnd_sel", bus.bus_sel, acc_sel);
      end
      prev_if_ack = e_if_ack;
      prev_mem_ack = e_mem_ack;
      if (acc_valid) begin
        if (e_done) acc_valid = 0;
        else acc_age++;
      end else if (bus.if_req || bus.mem_req) begin
        if (bus.if_req && bus.mem_req) pick = RR ? !model_last_mem : 1'b1;
        else pick = bus.mem_req;
        acc_valid = 1; acc_mem = pick; acc_age = 0;
        acc_we    = pick ? bus.mem_we : 1'b0;
        acc_addr  = pick ? bus.mem_addr : bus.if_addr;
        acc_wdata = pick ? bus.mem_wdata : 32'h0;
        acc_sel   = pick ? bus.mem_sel : 4'hF;
        model_last_mem = pick;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
